sub32_seq: RTL

Sequential 32-bit subtractor, the inverse companion to the team's 32-bit ripple adder. It computes `diff = a - b` as `a + ~b + 1` through a single 16-bit slice reused over two cycles: low half first, then high half using the registered inter-half carry. Valid/ready handshakes on both sides let it sit between a register-file read stage and a writeback stage.

---
 rtl/sub32_pkg.sv | 12 +
 rtl/sub16_slice.sv | 16 +
 rtl/sub32_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sub32_pkg.sv
// Shared widths and FSM state type for the sequential 32-bit subtractor.
package sub32_pkg;
   localparam int WORD_W = 32;
   localparam int HALF_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } sub32_state_t;
endpackage

// File: rtl/sub16_slice.sv
// Combinational 16-bit subtract slice: {o_cout, o_sum} = i_a + ~i_b + i_cin.
module sub16_slice
   import sub32_pkg::*;
(
   input  logic [HALF_W-1:0] i_a,
   input  logic [HALF_W-1:0] i_b,
   input  logic              i_cin,
   output logic [HALF_W-1:0] o_sum,
   output logic              o_cout
);
   logic [HALF_W:0] w_total;

   assign w_total = {1'b0, i_a} + {1'b0, ~i_b} + {{HALF_W{1'b0}}, i_cin};
   assign o_sum   = w_total[HALF_W-1:0];
   assign o_cout  = w_total[HALF_W];
endmodule

// File: rtl/sub32_seq.sv
// Sequential 32-bit subtractor reusing one 16-bit slice over two cycles (low half, then high half).
// Optional signed-overflow flag is built only when SUB32_OVF_EN is defined.
module sub32_seq
   import sub32_pkg::*;
(
   input  logic              clk,
   input  logic              areset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] diff,
   output logic              borrow,
   output logic              zero,
   output logic              ovf
);
   sub32_state_t r_state;
   sub32_state_t w_state_next;

   logic [WORD_W-1:0] r_a;
   logic [WORD_W-1:0] r_b;
   logic [WORD_W-1:0] r_diff;
   logic              r_carry_lo;
   logic              r_zero_lo;
   logic              r_borrow;
   logic              r_zero;

   logic              w_accept;
   logic              w_is_lo;
   logic              w_is_hi;
   logic [HALF_W-1:0] w_slice_a;
   logic [HALF_W-1:0] w_slice_b;
   logic              w_slice_cin;
   logic [HALF_W-1:0] w_slice_sum;
   logic              w_slice_cout;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign w_accept  = in_valid & in_ready;
   assign w_is_lo   = (r_state == LO);
   assign w_is_hi   = (r_state == HI);

   // Low half gets the two's-complement +1; high half takes the stored low carry.
   assign w_slice_a   = w_is_lo ? r_a[HALF_W-1:0] : r_a[WORD_W-1:HALF_W];
   assign w_slice_b   = w_is_lo ? r_b[HALF_W-1:0] : r_b[WORD_W-1:HALF_W];
   assign w_slice_cin = w_is_lo ? 1'b1 : r_carry_lo;

   sub16_slice u_slice (
      .i_a    (w_slice_a),
      .i_b    (w_slice_b),
      .i_cin  (w_slice_cin),
      .o_sum  (w_slice_sum),
      .o_cout (w_slice_cout)
   );

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = LO;
         LO:      w_state_next = HI;
         HI:      w_state_next = DONE;
         DONE:    if (out_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_a        <= '0;
         r_b        <= '0;
         r_diff     <= '0;
         r_carry_lo <= 1'b0;
         r_zero_lo  <= 1'b0;
         r_borrow   <= 1'b0;
         r_zero     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a <= a;
            r_b <= b;
         end
         if (w_is_lo) begin
            r_diff[HALF_W-1:0] <= w_slice_sum;
            r_carry_lo         <= w_slice_cout;
            r_zero_lo          <= (w_slice_sum == '0);
         end
         if (w_is_hi) begin
            r_diff[WORD_W-1:HALF_W] <= w_slice_sum;
            r_borrow                <= ~w_slice_cout;
            r_zero                  <= r_zero_lo & (w_slice_sum == '0);
         end
      end
   end

   assign diff   = r_diff;
   assign borrow = r_borrow;
   assign zero   = r_zero;

`ifdef SUB32_OVF_EN
   logic r_ovf;

   // Overflow only when operand signs differ and the result sign departs from the minuend.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_ovf <= 1'b0;
      end else if (w_is_hi) begin
         r_ovf <= (r_a[WORD_W-1] != r_b[WORD_W-1]) & (w_slice_sum[HALF_W-1] != r_a[WORD_W-1]);
      end
   end

   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif
endmodule
